// File: rtl/constants_pkg.sv
// Shared opcode constants, immediate-type enum and default datapath width
// for the immediate-generation pipeline.
package constants_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6,
    IMM_R    = 3'd7
  } imm_type_e;

endpackage

// File: rtl/igen.sv
// Combinational immediate generator for the I/S/B/U/J formats.
// Any other opcode yields IMM_NONE with a zero immediate; the caller
// layers SYSTEM/OP/illegal handling on top.
module igen
  import constants_pkg::*;
#(
  parameter int DWIDTH = DATA_WIDTH
) (
  input  logic [31:0]       insn,
  output logic [DWIDTH-1:0] imm,
  output imm_type_e         imm_type
);

  logic signed [31:0] imm32;

  // Pick the format from the opcode and assemble a sign-extended 32-bit value.
  always_comb begin
    imm32    = '0;
    imm_type = IMM_NONE;
    case (insn[6:0])
      OP_LUI, OP_AUIPC: begin
        imm32    = {insn[31:12], 12'b0};
        imm_type = IMM_U;
      end
      OP_JAL: begin
        imm32    = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
        imm_type = IMM_J;
      end
      OP_JALR, OP_LOAD, OP_IMM: begin
        imm32    = {{20{insn[31]}}, insn[31:20]};
        imm_type = IMM_I;
      end
      OP_BRANCH: begin
        imm32    = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
        imm_type = IMM_B;
      end
      OP_STORE: begin
        imm32    = {{20{insn[31]}}, insn[31:25], insn[11:7]};
        imm_type = IMM_S;
      end
      default: begin
        imm32    = '0;
        imm_type = IMM_NONE;
      end
    endcase
  end

  // imm32 is signed, so the width cast sign-extends up to DWIDTH.
  assign imm = DWIDTH'(imm32);

endmodule

// File: rtl/imm_pipe.sv
// Immediate decode stage with a small output FIFO: decodes the immediate,
// computes pc+imm at accept time, and counts illegal opcodes.
module imm_pipe
  import constants_pkg::*;
#(
  parameter int DWIDTH = DATA_WIDTH,
  parameter int DEPTH  = 2,
  parameter int CNTW   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       insn_i,
  input  logic [DWIDTH-1:0] pc_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DWIDTH-1:0] imm_o,
  output logic [2:0]        imm_type_o,
  output logic [DWIDTH-1:0] target_o,
  output logic              illegal_o,
  output logic [CNTW-1:0]   illegal_cnt_o
);

  localparam int         PW        = $clog2(DEPTH);
  localparam logic [PW:0] CNT_DEPTH = (PW+1)'(DEPTH);

  logic [PW:0]       count;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CNTW-1:0]   illegal_cnt;

  logic [DWIDTH-1:0] imm_mem [DEPTH];
  imm_type_e         type_mem[DEPTH];
  logic [DWIDTH-1:0] tgt_mem [DEPTH];
  logic              ill_mem [DEPTH];

  logic [DWIDTH-1:0] gen_imm, dec_imm;
  imm_type_e         gen_type, dec_type;
  logic              dec_ill;
  logic              push, pop;

  igen #(.DWIDTH(DWIDTH)) u_igen (
    .insn     (insn_i),
    .imm      (gen_imm),
    .imm_type (gen_type)
  );

  // Extend the igen result with SYSTEM (CSR uimm), OP and illegal opcodes.
  always_comb begin
    dec_imm  = gen_imm;
    dec_type = gen_type;
    dec_ill  = 1'b0;
    if (gen_type == IMM_NONE) begin
      if (insn_i[6:0] == OP_SYSTEM) begin
        dec_type = IMM_Z;
        dec_imm  = insn_i[14] ? DWIDTH'(insn_i[19:15]) : '0;
      end else if (insn_i[6:0] == OP_REG) begin
        dec_type = IMM_R;
        dec_imm  = '0;
      end else begin
        dec_type = IMM_NONE;
        dec_imm  = '0;
        dec_ill  = 1'b1;
      end
    end
  end

  // Ready depends only on occupancy (and reset), never on out_ready_i.
  assign in_ready_o  = !reset && (count < CNT_DEPTH);
  assign out_valid_o = (count != '0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  // Storage is unreset; stale entries are hidden by the out_valid_o mask.
  always_ff @(posedge clk) begin
    if (push) begin
      imm_mem[wr_ptr]  <= dec_imm;
      type_mem[wr_ptr] <= dec_type;
      tgt_mem[wr_ptr]  <= pc_i + dec_imm;
      ill_mem[wr_ptr]  <= dec_ill;
    end
  end

  // Occupancy, pointers and saturating illegal counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      illegal_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      if (push && dec_ill && !(&illegal_cnt))
        illegal_cnt <= illegal_cnt + CNTW'(1);
    end
  end

  assign imm_o         = out_valid_o ? imm_mem[rd_ptr]  : '0;
  assign imm_type_o    = out_valid_o ? type_mem[rd_ptr] : 3'b0;
  assign target_o      = out_valid_o ? tgt_mem[rd_ptr]  : '0;
  assign illegal_o     = out_valid_o ? ill_mem[rd_ptr]  : 1'b0;
  assign illegal_cnt_o = illegal_cnt;

endmodule

// File: tb/tb_imm_pipe.sv
// Directed bench for imm_pipe: decode vectors, flow control, reset and a
// 64-bit instance with a narrow counter for saturation.
module tb_imm_pipe;
  import constants_pkg::*;

  logic        clk = 1'b0;
  logic        reset;

  logic        in_valid, in_ready, out_valid, out_ready, illegal;
  logic [31:0] insn, pc, imm, target;
  logic [2:0]  imm_type;
  logic [15:0] ill_cnt;

  logic        in_valid64, in_ready64, out_valid64, out_ready64, illegal64;
  logic [31:0] insn64;
  logic [63:0] pc64, imm64, target64;
  logic [2:0]  imm_type64;
  logic [1:0]  ill_cnt64;

  int total  = 0;
  int passes = 0;

  always #5 clk = ~clk;

  imm_pipe dut (
    .clk(clk), .reset(reset),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .insn_i(insn), .pc_i(pc),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .imm_o(imm),
    .imm_type_o(imm_type), .target_o(target), .illegal_o(illegal),
    .illegal_cnt_o(ill_cnt)
  );

  imm_pipe #(.DWIDTH(64), .DEPTH(4), .CNTW(2)) dut64 (
    .clk(clk), .reset(reset),
    .in_valid_i(in_valid64), .in_ready_o(in_ready64), .insn_i(insn64), .pc_i(pc64),
    .out_valid_o(out_valid64), .out_ready_i(out_ready64), .imm_o(imm64),
    .imm_type_o(imm_type64), .target_o(target64), .illegal_o(illegal64),
    .illegal_cnt_o(ill_cnt64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else
      passes++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push one instruction into an empty dut, check the head, then pop it.
  task automatic dec_case(input string tag, input logic [31:0] i_insn, input logic [31:0] i_pc,
                          input logic [31:0] e_imm, input logic [2:0] e_type,
                          input logic [31:0] e_tgt, input logic e_ill);
    insn = i_insn; pc = i_pc; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_imm"},   64'(imm),       64'(e_imm));
    chk({tag, "_type"},  64'(imm_type),  64'(e_type));
    chk({tag, "_tgt"},   64'(target),    64'(e_tgt));
    chk({tag, "_ill"},   64'(illegal),   64'(e_ill));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_empty"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; insn = '0; pc = '0;
    in_valid64 = 1'b0; out_ready64 = 1'b0; insn64 = '0; pc64 = '0;
    step();
    step();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_cnt", 64'(ill_cnt), 64'd0);
    chk("rst_imm", 64'(imm), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 64'(in_ready), 64'd1);

    // Decode vectors
    dec_case("addi_m1", 32'hFFF00093, 32'h0,        32'hFFFFFFFF, 3'(IMM_I), 32'hFFFFFFFF, 1'b0);
    dec_case("jal",     32'h0080006F, 32'h100,      32'h8,        3'(IMM_J), 32'h108,      1'b0);
    dec_case("beq",     32'hFE000EE3, 32'h200,      32'hFFFFFFFC, 3'(IMM_B), 32'h1FC,      1'b0);
    dec_case("csr",     32'h3002D073, 32'h10,       32'h5,        3'(IMM_Z), 32'h15,       1'b0);
    dec_case("lui",     32'h12345037, 32'h4,        32'h12345000, 3'(IMM_U), 32'h12345004, 1'b0);
    dec_case("sw",      32'hFE112E23, 32'h40,       32'hFFFFFFFC, 3'(IMM_S), 32'h3C,       1'b0);
    dec_case("add",     32'h00208033, 32'h80,       32'h0,        3'(IMM_R), 32'h80,       1'b0);
    dec_case("csr_reg", 32'h30029073, 32'h20,       32'h0,        3'(IMM_Z), 32'h20,       1'b0);
    dec_case("jal_wrap",32'h0080006F, 32'hFFFFFFFC, 32'h8,        3'(IMM_J), 32'h4,        1'b0);
    chk("cnt_before_ill", 64'(ill_cnt), 64'd0);
    dec_case("illegal", 32'h0000007F, 32'h0,        32'h0,        3'(IMM_NONE), 32'h0,     1'b1);
    chk("cnt_after_ill", 64'(ill_cnt), 64'd1);

    // Flow control: fill with out_ready low, then stream at 1/cycle
    insn = 32'h0080006F; pc = 32'h1000; in_valid = 1'b1; out_ready = 1'b0;
    step();
    chk("fc_a_tgt", 64'(target), 64'h1008);
    chk("fc_ready1", 64'(in_ready), 64'd1);
    pc = 32'h2000;
    step();
    chk("fc_full_ready", 64'(in_ready), 64'd0);
    insn = 32'h0000007F; pc = 32'h3000;
    step();
    chk("fc_full_hold", 64'(in_ready), 64'd0);
    chk("fc_full_head", 64'(target), 64'h1008);
    chk("fc_full_cnt", 64'(ill_cnt), 64'd1);
    insn = 32'h0080006F; out_ready = 1'b1;
    step();
    chk("fc_pop_a_head", 64'(target), 64'h2008);
    chk("fc_pop_a_ready", 64'(in_ready), 64'd1);
    step();
    chk("fc_c_head", 64'(target), 64'h3008);
    chk("fc_c_valid", 64'(out_valid), 64'd1);
    pc = 32'h4000;
    step();
    chk("fc_d_head", 64'(target), 64'h4008);
    in_valid = 1'b0;
    step();
    chk("fc_drained", 64'(out_valid), 64'd0);
    step();
    chk("fc_underflow_valid", 64'(out_valid), 64'd0);
    chk("fc_underflow_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b0;

    // Reset with two entries buffered
    insn = 32'h0000007F; pc = 32'h0; in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    chk("rst2_full", 64'(in_ready), 64'd0);
    chk("rst2_cnt_pre", 64'(ill_cnt), 64'd3);
    reset = 1'b1;
    step();
    chk("rst2_valid", 64'(out_valid), 64'd0);
    chk("rst2_ready", 64'(in_ready), 64'd0);
    chk("rst2_cnt", 64'(ill_cnt), 64'd0);
    reset = 1'b0;
    step();
    chk("rst2_after_valid", 64'(out_valid), 64'd0);
    chk("rst2_after_ready", 64'(in_ready), 64'd1);

    // 64-bit instance
    insn64 = 32'hFFF00093; pc64 = 64'h0; in_valid64 = 1'b1; out_ready64 = 1'b0;
    step();
    in_valid64 = 1'b0;
    chk("w64_imm", imm64, 64'hFFFFFFFFFFFFFFFF);
    chk("w64_type", 64'(imm_type64), 64'(IMM_I));
    chk("w64_tgt", target64, 64'hFFFFFFFFFFFFFFFF);
    insn64 = 32'hFE000EE3; pc64 = 64'h1_0000_0000; in_valid64 = 1'b1; out_ready64 = 1'b1;
    step();
    in_valid64 = 1'b0;
    chk("w64_beq_imm", imm64, 64'hFFFFFFFFFFFFFFFC);
    chk("w64_beq_tgt", target64, 64'h0_FFFF_FFFC);
    step();
    chk("w64_empty", 64'(out_valid64), 64'd0);

    // Saturation of the 2-bit counter
    insn64 = 32'h0000007F; in_valid64 = 1'b1; out_ready64 = 1'b1;
    for (int k = 0; k < 3; k++) step();
    chk("sat_3", 64'(ill_cnt64), 64'd3);
    step();
    step();
    in_valid64 = 1'b0;
    chk("sat_hold", 64'(ill_cnt64), 64'd3);
    chk("sat_illegal_head", 64'(illegal64), 64'd1);
    step();
    chk("sat_drained", 64'(out_valid64), 64'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
